// File: rtl/ram_burst_master.sv
// Burst sequencer for a 1Kx8 single-port synchronous RAM.
// Writes come from a valid/ready stream; reads return through a 2-deep buffer.
`timescale 1ns/1ps
module ram_burst_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  dlv_q, dlv_d;
  logic              infl_q, infl_d;
  logic [1:0]        occ_q, occ_d;
  logic              rptr_q, rptr_d;
  logic              wptr_q, wptr_d;
  logic [DATA_W-1:0] fifo_q [2];

  logic              issue;
  logic              pop;
  logic              push;
  logic [2:0]        occ_sum;
  logic [2:0]        occ_lim;
  logic [LEN_W-1:0]  dlv_nxt;

  assign ram_addr = addr_q;
  assign ram_din  = wr_data;
  assign rd_data  = fifo_q[rptr_q];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    dlv_d     = dlv_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    issue     = 1'b0;
    pop       = 1'b0;
    push      = infl_q;
    occ_sum   = {1'b0, occ_q} + {2'b0, infl_q};
    occ_lim   = 3'd2;
    dlv_nxt   = dlv_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          dlv_d  = '0;
          if (cmd_len == '0)
            state_d = FIN;
          else if (cmd_we)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      WR: begin
        busy     = 1'b1;
        wr_ready = 1'b1;
        ram_cs   = wr_valid;
        ram_we   = wr_valid;
        if (wr_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q)
            state_d = FIN;
        end
      end
      RD: begin
        busy     = 1'b1;
        rd_valid = (occ_q != 2'd0);
        pop      = rd_valid & rd_ready;
        // A pop this cycle frees a slot for a read issued this cycle
        occ_lim  = 3'd2 + {2'b0, pop};
        issue    = (cnt_q < len_q) && (occ_sum < occ_lim);
        ram_cs   = issue;
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + LEN_W'(1);
        end
        dlv_nxt = dlv_q + {{(LEN_W-1){1'b0}}, pop};
        dlv_d   = dlv_nxt;
        if (dlv_nxt == len_q)
          state_d = FIN;
      end
      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      issue     = 1'b0;
      pop       = 1'b0;
      push      = 1'b0;
    end

    infl_d = issue;
    occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dlv_q   <= '0;
      infl_q  <= 1'b0;
      occ_q   <= 2'd0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dlv_q   <= dlv_d;
      infl_q  <= infl_d;
      occ_q   <= occ_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      if (push)
        fifo_q[wptr_q] <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 1Kx8 RAM.
`timescale 1ns/1ps
module tb_ram_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        done;
  logic        ram_cs;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_burst_master #(.ADDR_W(10), .DATA_W(8), .LEN_W(11)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: registered read, output floats when not just read
  logic [7:0] mem [1024];
  logic [7:0] dq;
  logic       dv = 1'b0;
  always @(posedge clk) begin
    dv <= ram_cs & ~ram_we;
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        dq <= mem[ram_addr];
    end
  end
  assign ram_dout = dv ? dq : 8'bz;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [9:0] a, input int l,
                          input logic [7:0] s);
    logic [9:0] ea;
    cyc();
    cmd_valid = 1'b1; cmd_we = 1'b1;
    cmd_addr = a; cmd_len = 11'(l);
    #1 chk("wr_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < l; i++) begin
      cyc();
      cmd_valid = 1'b0; wr_valid = 1'b1;
      wr_data = s + 8'(i);
      ea = a + 10'(i);
      #1;
      chk("wr_ready", wr_ready, 1);
      chk("wr_cs_we", {ram_cs, ram_we}, 2'b11);
      chk("wr_addr", ram_addr, ea);
      chk("wr_din", ram_din, s + 8'(i));
    end
    cyc();
    wr_valid = 1'b0;
    #1;
    chk("wr_done", done, 1);
    chk("wr_fin_cs", ram_cs, 0);
    cyc();
    #1;
    chk("wr_done_once", done, 0);
    chk("wr_cmd_ready_back", cmd_ready, 1);
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0 repeating
  task automatic do_read(input logic [9:0] a, input int l,
                         input logic [7:0] s, input int mode,
                         input bit timing);
    int iss, pcnt, first, fin, bound;
    logic [9:0] ea;
    iss = 0; pcnt = 0; first = -1; fin = -1;
    bound = (mode == 0) ? l + 20 : 3 * l + 20;
    cyc();
    cmd_valid = 1'b1; cmd_we = 1'b0;
    cmd_addr = a; cmd_len = 11'(l);
    #1 chk("rd_cmd_ready", cmd_ready, 1);
    for (int c = 0; c < bound; c++) begin
      cyc();
      cmd_valid = 1'b0;
      rd_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      #1;
      if (done) begin
        fin = c;
        chk("rd_fin_cs", ram_cs, 0);
        break;
      end
      if (ram_cs) begin
        ea = a + 10'(iss);
        chk("rd_we", ram_we, 0);
        chk("rd_addr", ram_addr, ea);
        chk("rd_occ_limit",
            (iss - pcnt - int'(rd_valid & rd_ready)) < 2, 1);
        iss++;
      end
      if (rd_valid && rd_ready) begin
        if (first < 0) first = c;
        chk("rd_data", rd_data, s + 8'(pcnt));
        pcnt++;
      end
    end
    rd_ready = 1'b0;
    chk("rd_done_seen", fin >= 0, 1);
    chk("rd_count", pcnt, l);
    chk("rd_issued", iss, l);
    if (timing) begin
      chk("rd_first_valid_cycle", first, 2);
      chk("rd_fin_cycle", fin, l + 2);
    end
    cyc();
    #1;
    chk("rd_done_once", done, 0);
    chk("rd_cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    int pc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_len = '0; wr_data = '0;
    wr_valid = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    // Reset forces outputs low even with traffic offered
    cyc();
    cmd_valid = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1;
    #1;
    chk("rst_outs",
        {ram_cs, ram_we, cmd_ready, wr_ready, rd_valid, busy, done}, 0);
    cyc();
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Write A0..A3 at 0x010 and confirm RAM contents
    do_write(10'h010, 4, 8'hA0);
    chk("mem_010", mem[10'h010], 8'hA0);
    chk("mem_011", mem[10'h011], 8'hA1);
    chk("mem_012", mem[10'h012], 8'hA2);
    chk("mem_013", mem[10'h013], 8'hA3);

    do_read(10'h010, 4, 8'hA0, 0, 1'b1);

    // Backpressured read
    do_write(10'h100, 6, 8'h50);
    do_read(10'h100, 6, 8'h50, 1, 1'b0);

    // Wrap around the top of the address space
    do_write(10'h3FE, 4, 8'hC0);
    chk("mem_3ff", mem[10'h3FF], 8'hC1);
    chk("mem_000", mem[10'h000], 8'hC2);
    do_read(10'h3FE, 4, 8'hC0, 0, 1'b1);

    // Zero-length command
    cyc();
    cmd_valid = 1'b1; cmd_we = 1'b0;
    cmd_addr = 10'h055; cmd_len = 11'd0;
    #1;
    chk("len0_ready", cmd_ready, 1);
    chk("len0_cs_accept", ram_cs, 0);
    cyc();
    cmd_valid = 1'b0;
    #1;
    chk("len0_done", done, 1);
    chk("len0_cs", ram_cs, 0);
    chk("len0_busy", busy, 1);
    cyc();
    #1;
    chk("len0_done_once", done, 0);
    chk("len0_ready_back", cmd_ready, 1);

    // Reset in the middle of a read burst
    do_write(10'h200, 8, 8'h70);
    cyc();
    cmd_valid = 1'b1; cmd_we = 1'b0;
    cmd_addr = 10'h200; cmd_len = 11'd8;
    #1 chk("rstrd_ready", cmd_ready, 1);
    pc = 0;
    for (int c = 0; c < 20 && pc < 2; c++) begin
      cyc();
      cmd_valid = 1'b0; rd_ready = 1'b1;
      #1;
      if (rd_valid) begin
        chk("rstrd_data", rd_data, 8'h70 + 8'(pc));
        pc++;
      end
    end
    chk("rstrd_two_delivered", pc, 2);
    cyc();
    rst = 1'b1;
    #1;
    chk("rstrd_cs", ram_cs, 0);
    chk("rstrd_rd_valid", rd_valid, 0);
    chk("rstrd_done", done, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rstrd_idle", {cmd_ready, busy, done, rd_valid}, 4'b1000);
    cyc();
    rd_ready = 1'b0;
    #1;
    chk("rstrd_no_done", {done, ram_cs}, 2'b00);
    do_read(10'h200, 8, 8'h70, 0, 1'b1);

    // Full 1024-word burst touches every address once
    do_write(10'h000, 1024, 8'h00);
    do_read(10'h000, 1024, 8'h00, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d",
             checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator-side sequencer for the 1K×8 single-port synchronous RAM: it accepts a burst command (direction, base address, length), then drives the RAM's `cs`/`we`/`addr`/`din` pins. Write bursts are fed from a valid/ready data stream. Read-burst data is returned on a valid/ready stream with full backpressure support. The block sits between any producer/consumer logic and the RAM, hiding the RAM's one-cycle read latency and its high-Z `dout` when deselected.

## Interface
- `ADDR_W`, 10, RAM address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 8, RAM data width.
- `LEN_W`, 11, burst-length width; max burst 2^ADDR_W words.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE with `rst` low.
- `cmd_we`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_W  burst base address.
- `cmd_len`  in  LEN_W  number of words; 0 is legal.
- `wr_data`  in  DATA_W  write stream data.
- `wr_valid`  in  1  write stream valid.
- `wr_ready`  out  1  write stream ready.
- `rd_data`  out  DATA_W  read stream data.
- `rd_valid`  out  1  read stream valid.
- `rd_ready`  in  1  read stream ready.
- `busy`  out  1  high in WR, RD, FIN.
- `done`  out  1  one-cycle pulse in FIN.
- `ram_cs`, `ram_we`  out  1  RAM chip select and write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_din`  out  DATA_W  RAM write data.
- `ram_dout`  in  DATA_W  RAM registered read data; valid only the cycle after a `cs`-asserted access, high-Z otherwise.

## Operation
- FSM states: IDLE, WR, RD, FIN.
- Reset behaviour:
  - While `rst` is high, `ram_cs`, `ram_we`, `cmd_ready`, `wr_ready`, `rd_valid`, `busy` and `done` are all forced to 0.
  - On the next edge the state is IDLE, the address and counters are 0, and the read buffer is empty.
  - Reset mid-burst aborts the burst with no `done` pulse. Any RAM read in flight is discarded.
- IDLE: when `cmd_valid & cmd_ready`, latch the address, length and direction.
  - `cmd_len` = 0 goes to FIN with no RAM access.
  - Otherwise go to WR (`cmd_we` = 1) or RD (`cmd_we` = 0).
- WR:
  - `wr_ready` = 1.
  - `ram_cs` = `ram_we` = `wr_valid`.
  - `ram_din` = `wr_data`; `ram_addr` = current address.
  - Each `wr_valid` cycle writes one word and increments the address (wrapping).
  - The last word goes to FIN.
- RD, issue rule:
  - Issue a read (`ram_cs` = 1, `ram_we` = 0) when issued < len and occ + inflight − pop < 2.
  - occ = read-buffer entries (0..2); inflight = a read issued the previous cycle; pop = `rd_valid & rd_ready`.
- RD, buffer:
  - Data is captured from `ram_dout` into a 2-entry FIFO on the cycle after issue.
  - `rd_valid` = occ ≠ 0; `rd_data` = FIFO head.
  - Go to FIN when the delivered count equals len.
- FIN: `done` = 1 for one cycle, then IDLE.
- `ram_dout` is never sampled except the cycle after a read issue.
- `wr_valid`/`rd_ready` are ignored outside WR/RD. `wr_ready` = 0 outside WR.
- Command fields are ignored while busy.

## Timing
- Command accepted at edge k:
  - The state at k+1 is WR/RD, or FIN if len = 0.
  - With len = 0, `done` is high for one cycle and `cmd_ready` is high again one cycle later.
- Write, L words with `wr_valid` held high: RAM writes occur on edges k+1..k+L. `done` is high in the following cycle. `cmd_ready` returns 1 cycle after that.
- Read, first word:
  - First issue occurs in the first RD cycle (c0).
  - `ram_dout` is valid in c1.
  - `rd_valid` is first high in c2.
- Read, throughput: with `rd_ready` held high, one word per cycle. L words are delivered in cycles c2..c(L+1), then FIN.
- Read, backpressure: with `rd_ready` low, issue stops once occ + inflight = 2. No word is lost or duplicated.
- Wrap: base 0x3FE, len 4 accesses 0x3FE, 0x3FF, 0x000, 0x001.
- Max len 1024: every address is accessed exactly once.

## Test plan
- Write len 4 @0x010, data A0..A3, `wr_valid` constant → `ram_we` pulses at 0x010..0x013, `done` is one cycle, the RAM model holds A0..A3.
- Read back len 4 @0x010, `rd_ready` = 1 → `rd_valid` on 4 consecutive cycles starting c2, data A0..A3, then `done`.
- Read len 6 with `rd_ready` toggling 1,0,0,1,… → data in order, no loss or duplication, `ram_cs` never leaves occ + inflight > 2.
- Write/read len 4 @0x3FE → addresses 0x3FE, 0x3FF, 0x000, 0x001; data round-trips.
- `cmd_len` = 0 → no `ram_cs`, `done` one cycle after accept, `cmd_ready` back on the next cycle.
- `rst` pulsed mid read burst (2 of 8 delivered) → `ram_cs`/`rd_valid` = 0 during reset, IDLE next, no `done`; a new read burst then returns correct data.
